// File: rtl/port_egress_pkg.sv
// Shared types and constants for the per-port egress store-and-forward buffer.
// Drain states: S_IDLE | waiting for a committed frame;  S_STREAM | presenting beats to the MAC
package port_egress_pkg;

  localparam int WORD_W  = 9;
  localparam int BYTE_W  = 8;
  localparam int SOF_BIT = 8;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } drain_state_e;

endpackage

// File: rtl/egress_length_fifo.sv
// Synchronous FIFO of committed frame lengths; push is refused when full, pop when empty.
module egress_length_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o    = (wr_q == rd_q);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/port_egress_buffer.sv
// Egress store-and-forward buffer: frames core bytes, drains only complete frames to the MAC.
// Optional EGRESS_STATS_EN adds saturating committed/dropped frame counters.
module port_egress_buffer
  import port_egress_pkg::*;
#(
  parameter int          DEPTH        = 64,
  parameter int          LENGTH_SLOTS = 4,
  parameter logic [15:0] IDLE_LIMIT   = 16'h0020
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [WORD_W-1:0]   core_transmit_data,
  input  logic                core_transmit_data_valid,
  output logic [BYTE_W-1:0]   tx_data,
  output logic                tx_valid,
  output logic                tx_first,
  output logic                tx_last,
  input  logic                tx_ready,
`ifdef EGRESS_STATS_EN
  output logic [15:0]         frames_committed_count,
  output logic [15:0]         frames_dropped_count,
`endif
  output logic                frame_dropped
);

  localparam int              ADDR_W   = $clog2(DEPTH);
  localparam int              LEN_W    = ADDR_W + 1;
  localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;

  logic [LEN_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  start_q, start_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       idle_q, idle_d;
  logic              open_q, open_d;
  logic              drop_q, drop_d;
  logic              dropped_q, dropped_d;
  logic              close;
  logic              push;
  logic [LEN_W-1:0]  used;
  logic [LEN_W-1:0]  used_post;

  logic [LEN_W-1:0]  rd_ptr_q;
  logic [LEN_W-1:0]  rd_ptr_inc;
  logic [LEN_W-1:0]  beats_q;
  drain_state_e      state_q;
  logic              pop;
  logic [LEN_W-1:0]  len_rdata;
  logic              len_full;
  logic              len_empty;
  logic [BYTE_W-1:0] tx_data_q;
  logic              tx_valid_q;
  logic              tx_first_q;
  logic              tx_last_q;

  logic              in_valid;
  logic              in_sof;
  logic [BYTE_W-1:0] in_byte;

  assign in_valid   = core_transmit_data_valid;
  assign in_sof     = core_transmit_data[SOF_BIT];
  assign in_byte    = core_transmit_data[BYTE_W-1:0];
  assign used       = wr_ptr_q - rd_ptr_q;
  assign rd_ptr_inc = rd_ptr_q + LEN_W'(1);
  assign pop        = (state_q == S_IDLE) && !len_empty;

  egress_length_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (LENGTH_SLOTS)
  ) u_len_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (len_q),
    .pop_i       (pop),
    .pop_data_o  (len_rdata),
    .full_o      (len_full),
    .empty_o     (len_empty)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    start_d   = start_q;
    len_d     = len_q;
    idle_d    = idle_q;
    open_d    = open_q;
    drop_d    = drop_q;
    dropped_d = 1'b0;
    push      = 1'b0;
    close     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q[ADDR_W-1:0];

    if (open_q && in_valid && in_sof)
      close = 1'b1;
    else if (open_q && !in_valid && (idle_q == IDLE_LIMIT - 16'd1))
      close = 1'b1;

    // Full length FIFO is judged before any pop this cycle, keeping commit independent of the drain.
    if (close) begin
      if (drop_q || len_full) begin
        wr_ptr_d  = start_q;
        dropped_d = 1'b1;
      end else begin
        push = 1'b1;
      end
      open_d = 1'b0;
      drop_d = 1'b0;
    end

    used_post = wr_ptr_d - rd_ptr_q;

    if (in_valid) begin
      idle_d = 16'd0;
      if (in_sof) begin
        open_d  = 1'b1;
        start_d = wr_ptr_d;
        len_d   = LEN_W'(1);
        if (used_post == FULL_CNT) begin
          drop_d = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_waddr = wr_ptr_d[ADDR_W-1:0];
          wr_ptr_d  = wr_ptr_d + LEN_W'(1);
        end
      end else if (open_q && !drop_q) begin
        if (used == FULL_CNT) begin
          drop_d   = 1'b1;
          wr_ptr_d = start_q;
        end else begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + LEN_W'(1);
          len_d    = len_q + LEN_W'(1);
        end
      end
    end else if (open_q) begin
      idle_d = close ? 16'd0 : idle_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= in_byte;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      start_q   <= '0;
      len_q     <= '0;
      idle_q    <= '0;
      open_q    <= 1'b0;
      drop_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      start_q   <= start_d;
      len_q     <= len_d;
      idle_q    <= idle_d;
      open_q    <= open_d;
      drop_q    <= drop_d;
      dropped_q <= dropped_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      beats_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_first_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!len_empty) begin
            state_q    <= S_STREAM;
            beats_q    <= len_rdata;
            tx_data_q  <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            tx_valid_q <= 1'b1;
            tx_first_q <= 1'b1;
            tx_last_q  <= (len_rdata == LEN_W'(1));
          end
        end
        S_STREAM: begin
          if (tx_ready) begin
            rd_ptr_q <= rd_ptr_inc;
            if (beats_q == LEN_W'(1)) begin
              state_q    <= S_IDLE;
              tx_valid_q <= 1'b0;
              tx_first_q <= 1'b0;
              tx_last_q  <= 1'b0;
            end else begin
              beats_q    <= beats_q - LEN_W'(1);
              tx_data_q  <= mem_q[rd_ptr_inc[ADDR_W-1:0]];
              tx_first_q <= 1'b0;
              tx_last_q  <= (beats_q == LEN_W'(2));
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign tx_first      = tx_first_q;
  assign tx_last       = tx_last_q;
  assign frame_dropped = dropped_q;

`ifdef EGRESS_STATS_EN
  logic [15:0] committed_q;
  logic [15:0] dropcnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      committed_q <= '0;
      dropcnt_q   <= '0;
    end else begin
      if (push && committed_q != 16'hFFFF)    committed_q <= committed_q + 16'd1;
      if (dropped_d && dropcnt_q != 16'hFFFF) dropcnt_q   <= dropcnt_q + 16'd1;
    end
  end

  assign frames_committed_count = committed_q;
  assign frames_dropped_count   = dropcnt_q;
`endif

endmodule

// File: tb/tb_port_egress_buffer.sv
// Directed bench for port_egress_buffer: inputs change 2ns after posedge, beats/drops sampled on negedge.
module tb_port_egress_buffer;

  logic       clock;
  logic       reset_n;
  logic [8:0] core_transmit_data;
  logic       core_transmit_data_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_first;
  logic       tx_last;
  logic       tx_ready;
  logic       frame_dropped;
`ifdef EGRESS_STATS_EN
  logic [15:0] frames_committed_count;
  logic [15:0] frames_dropped_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int drops    = 0;

  logic [9:0] beats [$];
  logic [9:0] exp_q [$];
  logic       hold_q = 1'b0;
  logic [7:0] hold_data = '0;
  logic [1:0] hold_flags = '0;

  port_egress_buffer dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .core_transmit_data       (core_transmit_data),
    .core_transmit_data_valid (core_transmit_data_valid),
    .tx_data                  (tx_data),
    .tx_valid                 (tx_valid),
    .tx_first                 (tx_first),
    .tx_last                  (tx_last),
    .tx_ready                 (tx_ready),
`ifdef EGRESS_STATS_EN
    .frames_committed_count   (frames_committed_count),
    .frames_dropped_count     (frames_dropped_count),
`endif
    .frame_dropped            (frame_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (hold_q && tx_valid) begin
        check("stall_hold_data", {24'd0, tx_data}, {24'd0, hold_data});
        check("stall_hold_flags", {30'd0, tx_first, tx_last}, {30'd0, hold_flags});
      end
      if (tx_valid && tx_ready) beats.push_back({tx_first, tx_last, tx_data});
      if (frame_dropped) drops++;
      hold_q     = tx_valid && !tx_ready;
      hold_data  = tx_data;
      hold_flags = {tx_first, tx_last};
    end else begin
      hold_q = 1'b0;
    end
  end

  task automatic word(input logic sof, input logic [7:0] b);
    @(posedge clock); #2;
    core_transmit_data_valid = 1'b1;
    core_transmit_data       = {sof, b};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #2;
      core_transmit_data_valid = 1'b0;
      core_transmit_data       = 9'h000;
    end
  endtask

  task automatic exp_beat(input logic f, input logic l, input logic [7:0] d);
    exp_q.push_back({f, l, d});
  endtask

  task automatic compare_beats(input string tag);
    check({tag, "_count"}, beats.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < beats.size()) check(tag, {22'd0, beats[i]}, {22'd0, exp_q[i]});
    beats.delete();
    exp_q.delete();
  endtask

  initial begin
    reset_n                  = 1'b0;
    core_transmit_data       = 9'h000;
    core_transmit_data_valid = 1'b0;
    tx_ready                 = 1'b0;
    #3;
    check("reset_outputs", {27'd0, tx_data[0], tx_valid, tx_first, tx_last, frame_dropped}, 32'd0);
    check("reset_data", {24'd0, tx_data}, 32'd0);
    #20;
    reset_n = 1'b1;

    // Basic 3-byte frame closed by the idle timeout.
    tx_ready = 1'b1;
    word(1'b1, 8'hAA); word(1'b0, 8'hBB); word(1'b0, 8'hCC);
    idle(32);
    idle(12);
    exp_beat(1, 0, 8'hAA); exp_beat(0, 0, 8'hBB); exp_beat(0, 1, 8'hCC);
    compare_beats("basic_frame");
    check("basic_no_drop", drops, 0);

    // Back-to-back frames: second SOF commits the first.
    word(1'b1, 8'h01); word(1'b0, 8'h02); word(1'b1, 8'h03); word(1'b0, 8'h04);
    idle(45);
    exp_beat(1, 0, 8'h01); exp_beat(0, 1, 8'h02); exp_beat(1, 0, 8'h03); exp_beat(0, 1, 8'h04);
    compare_beats("back_to_back");

    // 70-byte frame into a 64-byte RAM is dropped whole, then a short frame still passes.
    tx_ready = 1'b0;
    word(1'b1, 8'h00);
    for (int i = 1; i < 70; i++) word(1'b0, 8'(i));
    idle(33);
    idle(4);
    check("overflow_drop_pulse", drops, 1);
    check("overflow_no_output", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b1;
    word(1'b1, 8'hA0); word(1'b0, 8'hA1); word(1'b0, 8'hA2);
    idle(45);
    exp_beat(1, 0, 8'hA0); exp_beat(0, 0, 8'hA1); exp_beat(0, 1, 8'hA2);
    compare_beats("after_overflow");
    check("after_overflow_drops", drops, 1);

    // Six 1-byte frames while stalled: one is held on the line side, four fill the length FIFO, the sixth is dropped.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) word(1'b1, 8'h10 + 8'(i));
    idle(33);
    idle(4);
    check("slots_drop_pulse", drops, 2);
    check("slots_stalled_beat", {22'd0, tx_valid, tx_first, tx_last, tx_data}, {22'd0, 3'b111, 8'h10});
    tx_ready = 1'b1;
    idle(30);
    for (int i = 0; i < 5; i++) exp_beat(1, 1, 8'h10 + 8'(i));
    compare_beats("single_byte_frames");

    // Toggled ready during drain: order intact, stalled beats held (checked by the sampler).
    tx_ready = 1'b0;
    word(1'b1, 8'h30);
    for (int i = 1; i < 8; i++) word(1'b0, 8'h30 + 8'(i));
    idle(33);
    idle(3);
    repeat (40) begin
      @(posedge clock); #2;
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    idle(5);
    exp_beat(1, 0, 8'h30);
    for (int i = 1; i < 7; i++) exp_beat(0, 0, 8'h30 + 8'(i));
    exp_beat(0, 1, 8'h37);
    compare_beats("toggle_ready");

    // Stray word with no open frame is ignored silently.
    word(1'b0, 8'h55);
    idle(45);
    compare_beats("stray_word");
    check("stray_no_drop", drops, 2);

    // Reset mid-drain clears outputs at once and empties the buffer.
    tx_ready = 1'b0;
    word(1'b1, 8'h40); word(1'b0, 8'h41); word(1'b0, 8'h42);
    idle(33);
    idle(3);
    check("pre_reset_beat", {23'd0, tx_valid, tx_first, tx_data}, {23'd0, 2'b11, 8'h40});
    @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("reset_mid_flags", {28'd0, tx_valid, tx_first, tx_last, frame_dropped}, 32'd0);
    check("reset_mid_data", {24'd0, tx_data}, 32'd0);
    idle(2);
    @(posedge clock); #2;
    reset_n  = 1'b1;
    tx_ready = 1'b1;
    idle(40);
    compare_beats("post_reset_empty");
    word(1'b1, 8'h50); word(1'b0, 8'h51);
    idle(45);
    exp_beat(1, 0, 8'h50); exp_beat(0, 1, 8'h51);
    compare_beats("post_reset_frame");
    check("final_drops", drops, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
